// File: rtl/nco_cfg_sched_if.sv
// Host word-stream handshake for nco_cfg_sched: 32-bit command/data words with valid/ready.
interface nco_cfg_sched_if;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/nco_cfg_sched.sv
// Configuration scheduler for the NCO bank: parses host WRITE/COMMIT/CLEAR words into shadow
// registers and commits them atomically. Macro NCO_CFG_TIMED_COMMIT_EN defers commits to epoch.
module nco_cfg_sched #(
    parameter int unsigned NUM_CH     = 8,
    parameter int unsigned DATA_WIDTH = 28
) (
    input  logic                         clk,
    input  logic                         rst_n,
    nco_cfg_sched_if.slave               host,
    input  logic                         epoch,
    output logic [NUM_CH*DATA_WIDTH-1:0] fre_carrier_o,
    output logic [NUM_CH*DATA_WIDTH-1:0] fre_1023k_o,
    output logic [NUM_CH*DATA_WIDTH-1:0] pha_1023k_o,
    output logic                         cfg_update,
    output logic                         commit_pending,
    output logic [7:0]                   err_cnt
);
    localparam int unsigned VEC_W     = NUM_CH * DATA_WIDTH;
    localparam logic [3:0]  OP_WRITE  = 4'h1;
    localparam logic [3:0]  OP_COMMIT = 4'h2;
    localparam logic [3:0]  OP_CLEAR  = 4'h3;

    typedef enum logic [1:0] {HDR, DATA, WAIT_EP} state_t;

    state_t             state_q, state_d;
    logic               in_ready_q;
    logic [2:0]         ch_q;
    logic [1:0]         fld_q;
    logic               drop_q;
    logic [VEC_W-1:0]   sh_car, sh_f1k, sh_pha;

    logic               accept;
    logic [3:0]         hdr_op;
    logic [2:0]         hdr_ch;
    logic [1:0]         hdr_fld;
    logic               hdr_bad;

    logic               latch_hdr, wr_en, clr_en, commit_en, err_inc, pend_set, pend_clr;

    assign host.in_ready = in_ready_q;
    assign accept        = host.in_valid && in_ready_q;
    assign hdr_op        = host.in_data[31:28];
    assign hdr_ch        = host.in_data[26:24];
    assign hdr_fld       = host.in_data[21:20];
    assign hdr_bad       = (hdr_fld == 2'd3) || (32'(hdr_ch) >= NUM_CH);

`ifndef NCO_CFG_TIMED_COMMIT_EN
    logic unused_epoch;
    assign unused_epoch = epoch;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= HDR;
        else        state_q <= state_d;
    end

    // Next-state and control decode
    always_comb begin
        state_d   = state_q;
        latch_hdr = 1'b0;
        wr_en     = 1'b0;
        clr_en    = 1'b0;
        commit_en = 1'b0;
        err_inc   = 1'b0;
        pend_set  = 1'b0;
        pend_clr  = 1'b0;
        case (state_q)
            HDR: begin
                if (accept) begin
                    case (hdr_op)
                        OP_WRITE: begin
                            latch_hdr = 1'b1;
                            err_inc   = hdr_bad;
                            state_d   = DATA;
                        end
                        OP_COMMIT: begin
`ifdef NCO_CFG_TIMED_COMMIT_EN
                            pend_set = 1'b1;
                            state_d  = WAIT_EP;
`else
                            commit_en = 1'b1;
`endif
                        end
                        OP_CLEAR: clr_en  = 1'b1;
                        default:  err_inc = 1'b1;
                    endcase
                end
            end
            DATA: begin
                if (accept) begin
                    wr_en   = !drop_q;
                    state_d = HDR;
                end
            end
            WAIT_EP: begin
`ifdef NCO_CFG_TIMED_COMMIT_EN
                if (epoch) begin
                    commit_en = 1'b1;
                    pend_clr  = 1'b1;
                    state_d   = HDR;
                end
`else
                state_d = HDR;
`endif
            end
            default: state_d = HDR;
        endcase
    end

    // Handshake, latched header and status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_q     <= 1'b0;
            ch_q           <= 3'd0;
            fld_q          <= 2'd0;
            drop_q         <= 1'b0;
            cfg_update     <= 1'b0;
            commit_pending <= 1'b0;
            err_cnt        <= 8'd0;
        end else begin
            in_ready_q <= (state_d != WAIT_EP);
            cfg_update <= commit_en;
            if (latch_hdr) begin
                ch_q   <= hdr_ch;
                fld_q  <= hdr_fld;
                drop_q <= hdr_bad;
            end
            if (pend_set)      commit_pending <= 1'b1;
            else if (pend_clr) commit_pending <= 1'b0;
            if (err_inc && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
        end
    end

    // Shadow registers: per-channel field writes and bulk clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_car <= '0;
            sh_f1k <= '0;
            sh_pha <= '0;
        end else if (clr_en) begin
            sh_car <= '0;
            sh_f1k <= '0;
            sh_pha <= '0;
        end else if (wr_en) begin
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                if (ch_q == 3'(k)) begin
                    case (fld_q)
                        2'd0:    sh_car[k*DATA_WIDTH +: DATA_WIDTH] <= host.in_data[DATA_WIDTH-1:0];
                        2'd1:    sh_f1k[k*DATA_WIDTH +: DATA_WIDTH] <= host.in_data[DATA_WIDTH-1:0];
                        2'd2:    sh_pha[k*DATA_WIDTH +: DATA_WIDTH] <= host.in_data[DATA_WIDTH-1:0];
                        default: ;
                    endcase
                end
            end
        end
    end

    // Active registers: whole bank loaded from shadows on a single edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fre_carrier_o <= '0;
            fre_1023k_o   <= '0;
            pha_1023k_o   <= '0;
        end else if (commit_en) begin
            fre_carrier_o <= sh_car;
            fre_1023k_o   <= sh_f1k;
            pha_1023k_o   <= sh_pha;
        end
    end
endmodule
